// File: rtl/addsub_dispatch_pkg.sv
`default_nettype none
// addsub_dispatch_pkg -- shared op encodings, tag layout and overflow helper
// for the integer ALU add/sub issue slice. Rev 1.0
package addsub_dispatch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RA_W       = 5;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDU = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBU = 2'b11
    } op_e;

    // Per-op bookkeeping that travels alongside the adder pipeline.
    typedef struct packed {
        logic vld;
        logic kill;
        logic trap_en;
        logic sa;
        logic sb;
    } tag_t;

    // Signed overflow from effective operand signs and the result sign.
    function automatic logic ovf_detect(input logic sa, input logic sb, input logic res_msb);
        return (sa == sb) && (res_msb != sa);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_result_fifo.sv
`default_nettype none
// addsub_result_fifo -- synchronous result queue with occupancy count,
// synchronous clear and push+pop in the same cycle at any occupancy. Rev 1.0
module addsub_result_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);
    // A pop frees the head slot at this edge, so a full queue may still accept.
    assign do_push = push_i & (~full | do_pop) & ~clear_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/addsub_dispatch.sv
`default_nettype none
// addsub_dispatch -- issue/writeback stage around the non-stallable add/sub
// pipeline: tag tracking, overflow traps and a credit-protected result queue. Rev 1.0
module addsub_dispatch #(
    parameter int DATA_WIDTH  = addsub_dispatch_pkg::DATA_WIDTH,
    parameter int RA_W        = addsub_dispatch_pkg::RA_W,
    parameter int ADD_LATENCY = 2,
    parameter int RQ_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [RA_W-1:0]       in_rd,
    output logic                  add_valid,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_sub,
    input  logic [DATA_WIDTH-1:0] add_result,
    input  logic                  add_rdy,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [RA_W-1:0]       wb_rd,
    output logic                  wb_we,
    output logic                  wb_exc,
    output logic                  err_align
);

    import addsub_dispatch_pkg::*;

    localparam int NSTG = ADD_LATENCY + 1;
    localparam int CW   = $clog2(RQ_DEPTH) + 1;
    localparam int SW   = $clog2(RQ_DEPTH + NSTG + 1);
    localparam int QW   = DATA_WIDTH + RA_W + 2;
    localparam int MSB  = DATA_WIDTH - 1;

    logic                  accept;
    logic                  issue_vld_q;
    logic [DATA_WIDTH-1:0] issue_a_q;
    logic [DATA_WIDTH-1:0] issue_b_q;
    logic                  issue_sub_q;

    tag_t                  tag_q [NSTG];
    tag_t                  tag_d [NSTG];
    logic [RA_W-1:0]       rd_q  [NSTG];
    logic [RA_W-1:0]       rd_d  [NSTG];

    tag_t                  exit_tag;
    logic [RA_W-1:0]       exit_rd;
    logic                  push;
    logic                  ovf;
    logic                  err_align_q;
    logic                  err_align_d;

    logic [QW-1:0]         q_in;
    logic [QW-1:0]         q_head;
    logic                  q_valid;
    logic [CW-1:0]         q_count;
    logic [SW-1:0]         inflight;
    logic [SW-1:0]         credit_used;
    logic                  head_ovf;
    logic                  head_trap_en;

    // Credit: every live op already owns a queue slot, so pushes can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < NSTG; i++) begin
            if (tag_q[i].vld && !tag_q[i].kill) inflight = inflight + SW'(1);
        end
    end

    assign credit_used = SW'(q_count) + inflight;
    assign in_ready    = resetn & ~flush & (credit_used < SW'(RQ_DEPTH));
    assign accept      = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issue_vld_q <= 1'b0;
            issue_a_q   <= '0;
            issue_b_q   <= '0;
            issue_sub_q <= 1'b0;
        end else begin
            issue_vld_q <= accept;
            if (accept) begin
                issue_a_q   <= in_a;
                issue_b_q   <= in_b;
                issue_sub_q <= (in_op == OP_SUB) | (in_op == OP_SUBU);
            end
        end
    end

    assign add_valid = issue_vld_q;
    assign add_a     = issue_a_q;
    assign add_b     = issue_b_q;
    assign add_sub   = issue_sub_q;

    // Stage 0 loads alongside the issue register, so the last stage lines up with add_rdy.
    always_comb begin
        tag_d[0].vld     = accept;
        tag_d[0].kill    = 1'b0;
        tag_d[0].trap_en = (in_op == OP_ADD) | (in_op == OP_SUB);
        tag_d[0].sa      = in_a[MSB];
        tag_d[0].sb      = in_b[MSB] ^ in_op[1];
        rd_d[0]          = in_rd;
        for (int i = 1; i < NSTG; i++) begin
            tag_d[i]      = tag_q[i-1];
            tag_d[i].kill = tag_q[i-1].kill | flush;
            rd_d[i]       = rd_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NSTG; i++) begin
                tag_q[i] <= '0;
                rd_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                tag_q[i] <= tag_d[i];
                rd_q[i]  <= rd_d[i];
            end
        end
    end

    assign exit_tag    = tag_q[NSTG-1];
    assign exit_rd     = rd_q[NSTG-1];
    assign ovf         = ovf_detect(exit_tag.sa, exit_tag.sb, add_result[MSB]);
    assign push        = exit_tag.vld & ~exit_tag.kill & ~flush;
    assign q_in        = {add_result, exit_rd, ovf, exit_tag.trap_en};
    assign err_align_d = err_align_q | (exit_tag.vld != add_rdy);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_align_q <= 1'b0;
        else         err_align_q <= err_align_d;
    end

    assign err_align = err_align_q;

    addsub_result_fifo #(
        .WIDTH (QW),
        .DEPTH (RQ_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (wb_ready),
        .data_i  (q_in),
        .data_o  (q_head),
        .valid_o (q_valid),
        .count_o (q_count)
    );

    assign wb_valid     = q_valid;
    assign wb_data      = q_head[QW-1 -: DATA_WIDTH];
    assign wb_rd        = q_head[2 +: RA_W];
    assign head_ovf     = q_head[1];
    assign head_trap_en = q_head[0];
    assign wb_exc       = head_trap_en & head_ovf;
    assign wb_we        = ~wb_exc & (wb_rd != '0);

endmodule
`default_nettype wire

// File: tb/tb_addsub_dispatch.sv
`default_nettype none
// tb_addsub_dispatch -- randomized and directed bench with a queue-based
// reference model of the add/sub issue/writeback stage. Rev 1.0
module tb_addsub_dispatch;

    localparam int RQ = 8;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        add_valid;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sub;
    logic [31:0] add_result;
    logic        add_rdy;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        wb_exc;
    logic        err_align;
    logic        inj;

    addsub_dispatch dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .add_valid  (add_valid),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_result (add_result),
        .add_rdy    (add_rdy),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_exc     (wb_exc),
        .err_align  (err_align)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle adder stand-in sharing resetn.
    logic        p_v1, p_v2;
    logic [31:0] p_r1, p_r2;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_v1 <= 1'b0; p_v2 <= 1'b0; p_r1 <= '0; p_r2 <= '0;
        end else begin
            p_v1 <= add_valid;
            p_r1 <= add_sub ? add_a - add_b : add_a + add_b;
            p_v2 <= p_v1;
            p_r2 <= p_r1;
        end
    end
    assign add_rdy    = p_v2 | inj;
    assign add_result = p_r2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          npop = 0;
    int          nacc = 0;
    logic        prev_acc = 1'b0;
    logic [31:0] pa, pb;
    logic        psub;
    logic        err_exp = 1'b0;

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input int rdy);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = op[1] ? sa - sb : sa + sb;
        logic   ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.data = op[1] ? a - b : a + b;
        e.rd   = rd;
        e.exc  = !op[0] && ovf;
        e.we   = !e.exc && (rd != 5'd0);
        e.rdy  = rdy;
        return e;
    endfunction

    // Per-cycle compare against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic exp_wbv;
        logic acc;
        if (!resetn) begin
            q.delete();
            prev_acc = 1'b0;
            err_exp  = 1'b0;
        end else begin
            chk("in_ready", in_ready, !flush && (q.size() < RQ));
            exp_wbv = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("wb_valid", wb_valid, exp_wbv);
            if (exp_wbv && wb_valid) begin
                chk("wb_data", wb_data, q[0].data);
                chk("wb_rd",   wb_rd,   q[0].rd);
                chk("wb_we",   wb_we,   q[0].we);
                chk("wb_exc",  wb_exc,  q[0].exc);
            end
            chk("add_valid", add_valid, prev_acc);
            if (prev_acc) begin
                chk("add_a",   add_a,   pa);
                chk("add_b",   add_b,   pb);
                chk("add_sub", add_sub, psub);
            end
            chk("err_align", err_align, err_exp);
            if (inj) err_exp = 1'b1;
            acc = in_valid && in_ready;
            if (flush) q.delete();
            else if (wb_valid && wb_ready && q.size() > 0) begin
                void'(q.pop_front());
                npop++;
            end
            prev_acc = acc;
            if (acc) begin
                nacc++;
                pa = in_a; pb = in_b; psub = in_op[1];
                q.push_back(model(in_op, in_a, in_b, in_rd, cyc + 4));
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic [31:0] ed, input logic ee,
                              input logic ew);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
        @(negedge clk);
        chk("single_accept", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("single_early", wb_valid, 1'b0);
        @(negedge clk);
        chk("single_valid", wb_valid, 1'b1);
        chk("single_data",  wb_data,  ed);
        chk("single_rd",    wb_rd,    rd);
        chk("single_exc",   wb_exc,   ee);
        chk("single_we",    wb_we,    ew);
        step();
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        in_op = 2'($urandom_range(0, 3));
        in_a  = rand_val();
        in_b  = rand_val();
        in_rd = 5'($urandom_range(0, 31));
    endtask

    initial begin
        int base;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_a = '0; in_b = '0; in_rd = '0; wb_ready = 1'b1; inj = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_add_valid", add_valid, 1'b0);
        chk("rst_add_a",     add_a,     32'h0);
        chk("rst_add_sub",   add_sub,   1'b0);
        chk("rst_wb_valid",  wb_valid,  1'b0);
        chk("rst_wb_data",   wb_data,   32'h0);
        chk("rst_wb_we",     wb_we,     1'b0);
        chk("rst_wb_exc",    wb_exc,    1'b0);
        chk("rst_err_align", err_align, 1'b0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        step();

        // Directed single ops with hand-computed results.
        run_single(2'b00, 32'h7FFF_FFFF, 32'h1, 5'd3, 32'h8000_0000, 1'b1, 1'b0);
        run_single(2'b01, 32'h7FFF_FFFF, 32'h1, 5'd3, 32'h8000_0000, 1'b0, 1'b1);
        run_single(2'b10, 32'h8000_0000, 32'h1, 5'd4, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_single(2'b11, 32'h5,         32'h7, 5'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
        run_single(2'b00, 32'h1,         32'h2, 5'd0, 32'h3,         1'b0, 1'b0);

        // Back-to-back throughput.
        base = npop;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; rand_op();
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        chk("b2b_pops", npop - base, 20);

        // Backpressure: only RQ ops fit.
        base = nacc;
        wb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; rand_op();
            step();
        end
        chk("bp_accepts", nacc - base, RQ);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
        step();
        in_valid = 1'b0; wb_ready = 1'b1;
        base = npop;
        repeat (15) step();
        chk("bp_drain", npop - base, RQ);

        // Flush with three in flight and two queued.
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; rand_op();
            step();
        end
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; wb_ready = 1'b1;
        base = npop;
        repeat (8) step();
        chk("flush_no_wb", npop - base, 0);
        run_single(2'b00, 32'd10, 32'd20, 5'd7, 32'd30, 1'b0, 1'b1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            logic f;
            f        = ($urandom_range(0, 49) == 0);
            flush    = f;
            in_valid = ($urandom_range(0, 9) < 7);
            wb_ready = f ? 1'b0 : ($urandom_range(0, 9) < 6);
            rand_op();
            step();
        end
        flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        chk("drain_empty", wb_valid, 1'b0);
        step();

        // Spurious adder response with the tag pipe empty.
        base = npop;
        repeat (5) step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("spur_err", err_align, 1'b1);
        chk("spur_no_push", wb_valid, 1'b0);
        repeat (10) step();
        @(negedge clk);
        chk("spur_sticky", err_align, 1'b1);
        chk("spur_no_pop", npop - base, 0);
        step();

        resetn = 1'b0;
        @(negedge clk);
        chk("rst2_err_align", err_align, 1'b0);
        chk("rst2_in_ready",  in_ready,  1'b0);
        chk("rst2_add_valid", add_valid, 1'b0);
        chk("rst2_wb_valid",  wb_valid,  1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_dispatch.md
# addsub_dispatch

Issue and writeback stage wrapped around the two-cycle unsigned add/sub pipeline in the integer ALU. It accepts decoded ADD/ADDU/SUB/SUBU operations with a valid/ready handshake and drives the adder. It tracks destination tags alongside the adder pipeline, computes MIPS signed-overflow traps itself, and buffers results in a credit-protected queue so that writeback backpressure never stalls the non-stallable adder.

## Interface
- DATA_WIDTH, 32, operand/result width
- RA_W, 5, register address width
- ADD_LATENCY, 2, cycles from adder sampling add_valid to add_rdy
- RQ_DEPTH, 8, result queue entries; power of two, must be >= ADD_LATENCY+3 for full throughput
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous kill of all in-flight and queued ops
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_op  in  2  00 ADD, 01 ADDU, 10 SUB, 11 SUBU
- in_a, in_b  in  DATA_WIDTH  rs, rt values
- in_rd  in  RA_W  destination register
- add_valid  out  1  adder request
- add_a, add_b  out  DATA_WIDTH  adder operands (unmodified)
- add_sub  out  1  1 = subtract
- add_result  in  DATA_WIDTH  adder sum
- add_rdy  in  1  adder result valid
- wb_valid  out  1  queue head valid
- wb_ready  in  1  writeback consumes head
- wb_data  out  DATA_WIDTH  result
- wb_rd  out  RA_W  destination
- wb_we  out  1  register write enable
- wb_exc  out  1  integer overflow trap
- err_align  out  1  sticky: add_rdy disagrees with the tag pipeline

## Operation
- Issue register: on accept, capture a, b, op, rd. add_valid/add_a/add_b/add_sub are driven from this register in the next cycle. add_sub = op[1].
- Tag pipe: ADD_LATENCY+1 stages carrying {vld, kill, rd, trap_en=~op[0], sa=a[MSB], sb=b[MSB]^op[1]}. Shifts every cycle.
- At tag-pipe exit (same cycle as the expected add_rdy):
  - if vld != add_rdy, set err_align.
  - if vld & ~kill, push {result, rd, ovf, trap_en} to the queue.
- Overflow: ovf = (sa==sb) & (result[MSB]!=sa). The adder carry flag is not used.
- Head outputs:
  - wb_exc = trap_en & ovf
  - wb_we = ~wb_exc & (rd!=0)
  - wb_data is always driven from the head, including on trap.
- Credit: inflight = count of vld&~kill across issue reg and tag stages. in_ready = ~flush & (occupancy + inflight < RQ_DEPTH). Same-cycle pops give no credit.
- Queue: pop on wb_valid & wb_ready. Simultaneous push and pop is legal at any occupancy, including full.
- flush:
  - sets kill on all tag stages and issue reg
  - empties the queue at the clock edge
  - in_ready=0 that cycle
  - add_valid still follows the issue register (the adder cannot be cancelled)
  - killed results are discarded silently and still checked for alignment.

## Timing
- Accept at end of cycle 0 → add_valid in cycle 1 → add_rdy in cycle 1+ADD_LATENCY → wb_valid in cycle 2+ADD_LATENCY (4 at default) when the queue is empty.
- Sustains one op/cycle with wb_ready held high.
- Reset values: in_ready 0 during reset and 1 after; add_valid, add_a, add_b, add_sub, wb_valid, wb_data, wb_rd, wb_we, wb_exc, err_align all 0. Queue pointers and tag pipe are cleared.
- Reset mid-operation discards everything; the adder shares resetn.
- err_align clears only on reset.

## Structure
- Shared ALU package: op encoding constants (OP_ADD..OP_SUBU), tag struct/width, DATA_WIDTH, RA_W.
- One sub-module: addsub_result_fifo (synchronous FIFO, count output, simultaneous push/pop).
- Tag pipe, credit logic and overflow detection stay inline.

## Test plan
- Single ADD: 0x7FFFFFFF + 1 → wb_valid in cycle 4, wb_exc=1, wb_we=0, wb_data=0x80000000.
- ADDU with the same operands → wb_exc=0, wb_we=1 (rd=3), data 0x80000000. SUB 0x80000000 − 1 → trap; SUBU 5 − 7 → 0xFFFFFFFE, no trap.
- Back-to-back 20 ops with wb_ready=1 → in_ready never drops, results in order, add_valid high 20 consecutive cycles.
- wb_ready=0 with continuous in_valid → exactly 8 ops accepted, in_ready low thereafter. Releasing wb_ready drains in order with no loss.
- flush with 3 in flight and 2 queued → no wb_valid for those 5. The next op issued after flush returns in 4 cycles; err_align stays 0.
- Inject a spurious add_rdy with the tag pipe empty → err_align=1 sticky, and no queue push.
